// File: rtl/mole_pkg.sv
// Shared constants for the whack-a-mole round controller: state codes,
// hole/score widths and the spawn helper.
package mole_pkg;

  localparam int NUM_HOLES = 5;
  localparam int HOLE_W    = 3;
  localparam int SCORE_W   = 8;
  localparam int TMR_W     = 8;

  localparam logic [HOLE_W-1:0] INVALID_GUESS = 3'd5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SPAWN  = 3'd1;
  localparam logic [2:0] ST_SHOW   = 3'd2;
  localparam logic [2:0] ST_RESULT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Map a random value onto a hole, stepping to the next hole on a repeat.
  function automatic logic [HOLE_W-1:0] pick_hole(input logic [4:0] r,
                                                  input logic [HOLE_W-1:0] prev);
    logic [4:0] m;
    m = r % 5'(NUM_HOLES);
    if (m[HOLE_W-1:0] == prev)
      m = (m == 5'(NUM_HOLES - 1)) ? 5'd0 : m + 5'd1;
    return m[HOLE_W-1:0];
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down counter that decrements on tick and flags zero.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)                         count <= '0;
    else if (load)                   count <= load_val;
    else if (tick && count != '0)    count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mole_round_ctrl.sv
// Round controller: spawns a mole, judges guesses or timeouts, keeps score
// and round count, and stops after ROUNDS rounds.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int ROUNDS       = 10,
  parameter int SHOW_TICKS   = 8,
  parameter int RESULT_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               guess_valid,
  input  logic [HOLE_W-1:0]  guess,
  input  logic [4:0]         rand_val,
  output logic [NUM_HOLES-1:0] mole_onehot,
  output logic [HOLE_W-1:0]  mole_idx,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         round,
  output logic               done
);

  logic [2:0]       state;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             expire;
  logic             correct;
  logic [3:0]       next_round;

  assign expire     = tick && tmr_zero;
  assign correct    = (guess < INVALID_GUESS) && (guess == mole_idx);
  assign next_round = round + 4'd1;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state == ST_SPAWN) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(SHOW_TICKS - 1);
    end else if (state == ST_SHOW && (guess_valid || expire)) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(RESULT_TICKS - 1);
    end
  end

  tick_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mole_idx <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      score    <= '0;
      round    <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: if (start) begin
          state <= ST_SPAWN;
          score <= '0;
          round <= '0;
        end
        ST_SPAWN: begin
          mole_idx <= pick_hole(rand_val, mole_idx);
          state    <= ST_SHOW;
        end
        ST_SHOW: begin
          // A guess on the same edge as the timeout takes precedence.
          if (guess_valid) begin
            state <= ST_RESULT;
            if (correct) begin
              hit <= 1'b1;
              if (score != '1) score <= score + 1'b1;
            end else begin
              miss <= 1'b1;
            end
          end else if (expire) begin
            state <= ST_RESULT;
            miss  <= 1'b1;
          end
        end
        ST_RESULT: if (expire) begin
          round <= next_round;
          state <= (next_round == 4'(ROUNDS)) ? ST_DONE : ST_SPAWN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mole_onehot = (state == ST_SHOW) ? (NUM_HOLES'(1) << mole_idx) : '0;
  assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed game walk-through followed by random play, checked every cycle
// against a tick-counting model of the game rules.
module tb_mole_round_ctrl;

  localparam int ROUNDS = 3, SHOW_TICKS = 4, RESULT_TICKS = 2;
  localparam int P_IDLE = 0, P_SPAWN = 1, P_SHOW = 2, P_RESULT = 3, P_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1, tick = 1'b0, start = 1'b0, guess_valid = 1'b0;
  logic [2:0] guess = '0;
  logic [4:0] rand_val = '0;
  logic [4:0] mole_onehot;
  logic [2:0] mole_idx;
  logic       hit, miss, done;
  logic [7:0] score;
  logic [3:0] round;

  int n_tests = 0, n_fail = 0;

  // Model: phase of the game plus ticks consumed within the current phase.
  int m_phase = P_IDLE, m_ticks = 0, m_mole = 0, m_score = 0, m_round = 0;
  bit m_hit = 0, m_miss = 0;

  always #5 clk = ~clk;

  mole_round_ctrl #(.ROUNDS(ROUNDS), .SHOW_TICKS(SHOW_TICKS), .RESULT_TICKS(RESULT_TICKS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .guess_valid(guess_valid),
    .guess(guess), .rand_val(rand_val), .mole_onehot(mole_onehot), .mole_idx(mole_idx),
    .hit(hit), .miss(miss), .score(score), .round(round), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, s, t, g, input int gs, input int rv);
    int h;
    m_hit = 0; m_miss = 0;
    if (r) begin
      m_phase = P_IDLE; m_ticks = 0; m_mole = 0; m_score = 0; m_round = 0;
      return;
    end
    case (m_phase)
      P_IDLE, P_DONE: if (s) begin m_phase = P_SPAWN; m_score = 0; m_round = 0; end
      P_SPAWN: begin
        h = rv % 5;
        if (h == m_mole) h = (h + 1) % 5;
        m_mole = h; m_phase = P_SHOW; m_ticks = 0;
      end
      P_SHOW: begin
        if (g) begin
          if (gs == m_mole) begin m_hit = 1; if (m_score < 255) m_score++; end
          else m_miss = 1;
          m_phase = P_RESULT; m_ticks = 0;
        end else if (t) begin
          m_ticks++;
          if (m_ticks == SHOW_TICKS) begin m_miss = 1; m_phase = P_RESULT; m_ticks = 0; end
        end
      end
      P_RESULT: if (t) begin
        m_ticks++;
        if (m_ticks == RESULT_TICKS) begin
          m_round++;
          m_phase = (m_round == ROUNDS) ? P_DONE : P_SPAWN;
          m_ticks = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    chk("hit", hit, m_hit);
    chk("miss", miss, m_miss);
    chk("hit_and_miss", hit & miss, 0);
    chk("score", score, m_score);
    chk("round", round, m_round);
    chk("done", done, m_phase == P_DONE);
    chk("mole_onehot", mole_onehot, (m_phase == P_SHOW) ? (32'd1 << m_mole) : 32'd0);
    chk("mole_idx", mole_idx, m_mole);
  endtask

  task automatic step(input bit r, s, t, g, input logic [2:0] gs, input logic [4:0] rv);
    rst = r; start = s; tick = t; guess_valid = g; guess = gs; rand_val = rv;
    @(posedge clk);
    model(r, s, t, g, int'(gs), int'(rv));
    #1;
    check_all();
  endtask

  task automatic nop();           step(0, 0, 0, 0, 3'd0, 5'd0); endtask
  task automatic tk();            step(0, 0, 1, 0, 3'd0, 5'd0); endtask
  task automatic gv(input logic [2:0] g); step(0, 0, 0, 1, g, 5'd0); endtask
  task automatic spawn(input logic [4:0] rv); step(0, 0, 0, 0, 3'd0, rv); endtask

  initial begin
    step(1, 0, 0, 0, 3'd0, 5'd0);
    chk("rst_score", score, 0); chk("rst_done", done, 0); chk("rst_onehot", mole_onehot, 0);

    // Game 1: hit, wrong-hole miss, timeout miss.
    step(0, 1, 0, 0, 3'd0, 5'd0);
    spawn(5'd7);
    chk("r1_mole_idx", mole_idx, 2); chk("r1_onehot", mole_onehot, 5'b00100);
    gv(3'd2);
    chk("r1_hit", hit, 1); chk("r1_score", score, 1);
    nop(); chk("r1_hit_one_clk", hit, 0);
    tk(); tk(); chk("r1_round", round, 1);
    spawn(5'd12); chk("r2_repeat_avoid", mole_idx, 3);
    gv(3'd4); chk("r2_miss", miss, 1); chk("r2_score", score, 1);
    nop(); chk("r2_miss_one_clk", miss, 0);
    tk(); tk();
    spawn(5'd0);
    tk(); tk(); tk(); chk("r3_still_shown", mole_onehot, 5'b00001);
    tk(); chk("r3_timeout_miss", miss, 1); chk("r3_onehot_off", mole_onehot, 0);
    tk(); chk("r3_result_hold", done, 0);
    tk(); chk("g1_done", done, 1); chk("g1_round", round, 3);
    gv(3'd0); chk("g1_ignored_hit", hit, 0); chk("g1_ignored_score", score, 1);
    step(0, 1, 0, 0, 3'd0, 5'd0);
    chk("restart_score", score, 0); chk("restart_round", round, 0); chk("restart_done", done, 0);

    // Game 2: hit, same-edge guess/timeout hit, reset mid-SHOW.
    spawn(5'd5); chk("g2r1_mole", mole_idx, 1);
    gv(3'd1); tk(); tk();
    spawn(5'd9); chk("g2r2_mole", mole_idx, 4);
    tk(); tk(); tk();
    step(0, 0, 1, 1, 3'd4, 5'd0);
    chk("same_edge_hit", hit, 1); chk("same_edge_no_miss", miss, 0); chk("same_edge_score", score, 2);
    tk(); tk();
    spawn(5'd2);
    step(1, 0, 0, 0, 3'd0, 5'd0);
    chk("midrst_score", score, 0); chk("midrst_onehot", mole_onehot, 0); chk("midrst_idx", mole_idx, 0);
    gv(3'd0); chk("idle_guess_hit", hit, 0); chk("idle_guess_miss", miss, 0);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      bit r, s, t, g;
      logic [2:0] gs;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 15) == 0);
      t  = ($urandom_range(0, 2) == 0);
      g  = ($urandom_range(0, 5) == 0);
      gs = $urandom_range(0, 1) ? 3'(m_mole) : 3'($urandom_range(0, 7));
      step(r, s, t, g, gs, 5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_round_ctrl.md
MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 10, rounds per game (1..15).
REQ-002 Parameter SHOW_TICKS, default 8, ticks a mole stays up before timeout (1..255).
REQ-003 Parameter RESULT_TICKS, default 2, ticks the hit/miss result is held (1..255).
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 tick  in  1  one-clk pulse, slow time base (debounce clock-enable rate).
REQ-007 start  in  1  one-clk pulse, begin a game.
REQ-008 guess_valid  in  1  one-clk pulse, debounced button press.
REQ-009 guess  in  3  hole index 0..4 (U,D,L,R,C); 5..7 invalid.
REQ-010 rand  in  5  free-running LFSR value.
REQ-011 mole_onehot  out  5  lit hole, one-hot, zero when no mole shown.
REQ-012 mole_idx  out  3  current mole hole 0..4.
REQ-013 hit / miss  out  1 each  one-clk result pulses.
REQ-014 score  out  8  hits this game, saturating.
REQ-015 round  out  4  completed rounds this game.
REQ-016 done  out  1  high while game over.

Function
REQ-017 FSM states: IDLE, SPAWN, SHOW, RESULT, DONE.
REQ-018 IDLE/DONE + start -> SPAWN; score and round cleared to 0 on that edge.
REQ-019 start outside IDLE/DONE ignored.
REQ-020 SPAWN lasts one clk: mole_idx <= rand mod 5; if equal to previous mole_idx, use (rand mod 5 + 1) mod 5; timer <= SHOW_TICKS-1; -> SHOW.
REQ-021 SHOW: mole_onehot = 1 << mole_idx; all other states mole_onehot = 0.
REQ-022 SHOW + guess_valid with guess == mole_idx -> hit pulse next cycle, score+1 saturating at 255, -> RESULT.
REQ-023 SHOW + guess_valid with guess != mole_idx (incl. 5..7) -> miss pulse next cycle, -> RESULT.
REQ-024 SHOW + tick with timer == 0 and no guess_valid -> miss pulse (timeout), -> RESULT; tick with timer > 0 decrements timer.
REQ-025 guess_valid and expiring tick on same edge: guess wins.
REQ-026 Entering RESULT loads timer <= RESULT_TICKS-1; RESULT + tick at timer 0 -> round+1; -> DONE if new round == ROUNDS, else SPAWN.
REQ-027 guess_valid outside SHOW ignored, no pulse, no score change.
REQ-028 done = 1 only in DONE; score and round held in DONE until next start.
REQ-029 Hit and miss never asserted in the same cycle; each at most once per round.

Reset
REQ-030 rst, sampled on posedge clk, overrides all inputs, including mid-game: state IDLE, mole_onehot 0, mole_idx 0, hit 0, miss 0, score 0, round 0, done 0, timers 0.
REQ-031 No initial-value reliance; all state reaches defined values via rst only.

Structure
REQ-032 Package mole_pkg: state enumeration, NUM_HOLES = 5, hole index width 3, score width 8, invalid-guess code 5.
REQ-033 One sub-module, tick_timer: loadable tick-enabled down counter with zero flag, used for both SHOW and RESULT.
REQ-034 FSM, scoring and spawn logic in mole_round_ctrl; no combinational path from guess_valid to hit/miss.

Verification (ROUNDS=3, SHOW_TICKS=4, RESULT_TICKS=2)
REQ-035 rst, then start, rand=7 -> SPAWN then SHOW with mole_idx=2, mole_onehot=00100; guess_valid, guess=2 -> hit 1 clk, score=1.
REQ-036 Previous mole 2, rand=12 -> mole_idx=3 (repeat avoided); guess=4 -> miss 1 clk, score unchanged.
REQ-037 SHOW, no guess, 4 ticks -> miss on 4th tick, mole_onehot=0; RESULT lasts 2 ticks, round increments.
REQ-038 Same-edge guess_valid (correct) and expiring tick -> hit, not miss.
REQ-039 Three rounds complete -> done=1, round=3; extra guess_valid ignored; start -> score=0, round=0, SPAWN.
REQ-040 rst asserted mid-SHOW with score=2 -> next cycle all outputs 0, state IDLE; guess_valid ignored until start.
